rename_stage: RTL and testbench

- Register rename stage directly downstream of decode. Consumes up to FRONTEND_WIDTH `instr_dec_t` per cycle.
- Maps architectural rs1/rs2/rd onto PHYS_REGS_SIZE physical registers using a speculative RAT, a retirement RAT (RRAT) and a circular free list.
- Emits renamed bundles to dispatch through a registered output stage.
- Commit returns stale physical registers; flush restores speculative state from committed state in one cycle.

---
 rtl/rename_stage_pkg.sv | 32 +++
 rtl/rename_stage_if.sv | 30 +++
 rtl/rename_free_list.sv | 77 +++++++
 rtl/rename_stage.sv | 136 +++++++++++++
 tb/tb_rename_stage.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_stage_pkg.sv
// Shared types and sizing for the rename stage: decoded/renamed instruction
// records and free-list geometry.
package rename_stage_pkg;

    localparam int unsigned FRONTEND_WIDTH      = 2;
    localparam int unsigned PHYS_REGS_SIZE      = 64;
    localparam int unsigned PHYS_REGS_ADDR_SIZE = 6;
    localparam int unsigned ARCH_REGS           = 32;
    localparam int unsigned FREE_LIST_DEPTH     = PHYS_REGS_SIZE - ARCH_REGS;

    typedef logic [PHYS_REGS_ADDR_SIZE-1:0] ptag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_v;
        logic        rs2_v;
        logic        rd_v;
    } instr_dec_t;

    typedef struct packed {
        instr_dec_t dec;
        ptag_t      prs1;
        ptag_t      prs2;
        ptag_t      prd;
        ptag_t      old_prd;
    } ren_instr_t;

endpackage

// File: rtl/rename_stage_if.sv
// Decode-to-rename, rename-to-dispatch, commit and flush signals of the
// rename stage; slave is the rename stage's view.
interface rename_stage_if;
    import rename_stage_pkg::*;

    logic [FRONTEND_WIDTH-1:0]       dec_valid_i;
    instr_dec_t [FRONTEND_WIDTH-1:0] dec_instr_i;
    logic                            dec_ready_o;
    logic [FRONTEND_WIDTH-1:0]       ren_valid_o;
    ren_instr_t [FRONTEND_WIDTH-1:0] ren_instr_o;
    logic                            ren_ready_i;
    logic [FRONTEND_WIDTH-1:0]       commit_valid_i;
    logic [FRONTEND_WIDTH-1:0][4:0]  commit_rd_i;
    ptag_t [FRONTEND_WIDTH-1:0]      commit_prd_i;
    ptag_t [FRONTEND_WIDTH-1:0]      commit_old_prd_i;
    logic                            flush_i;

    modport slave (
        input  dec_valid_i, dec_instr_i, ren_ready_i,
        input  commit_valid_i, commit_rd_i, commit_prd_i, commit_old_prd_i, flush_i,
        output dec_ready_o, ren_valid_o, ren_instr_o
    );

    modport master (
        output dec_valid_i, dec_instr_i, ren_ready_i,
        output commit_valid_i, commit_rd_i, commit_prd_i, commit_old_prd_i, flush_i,
        input  dec_ready_o, ren_valid_o, ren_instr_o
    );

endinterface

// File: rtl/rename_free_list.sv
// Circular free list of physical tags: allocation at head, frees at tail,
// commit_head tracks the oldest uncommitted allocation so flush can rewind head.
module rename_free_list import rename_stage_pkg::*; #(
    parameter int unsigned WIDTH = FRONTEND_WIDTH,
    parameter int unsigned DEPTH = FREE_LIST_DEPTH,
    parameter int unsigned PRW   = PHYS_REGS_ADDR_SIZE,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned PopW = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PopW-1:0]           pop_cnt_i,
    input  logic [WIDTH-1:0]          push_valid_i,
    input  logic [WIDTH-1:0][PRW-1:0] push_tag_i,
    input  logic                      flush_i,
    output logic [CntW-1:0]           count_o,
    output logic [WIDTH-1:0][PRW-1:0] head_tags_o
);

    // DEPTH is a power of two so pointers wrap naturally.
    logic [PRW-1:0]            mem_q [DEPTH];
    logic [PtrW-1:0]           head_q, head_d, commit_head_q, commit_head_d, tail_q, tail_d;
    logic [CntW-1:0]           count_q, count_d, push_cnt;
    logic [WIDTH-1:0][PtrW-1:0] push_addr;

    always_comb begin
        tail_d   = tail_q;
        push_cnt = '0;
        for (int k = 0; k < WIDTH; k++) begin
            push_addr[k] = tail_d;
            if (push_valid_i[k]) begin
                tail_d   = tail_d + PtrW'(1);
                push_cnt = push_cnt + CntW'(1);
            end
        end
        commit_head_d = commit_head_q + PtrW'(push_cnt);
        head_d        = head_q + PtrW'(pop_cnt_i);
        count_d       = count_q - CntW'(pop_cnt_i) + push_cnt;
        if (flush_i) begin
            head_d  = commit_head_d;
            count_d = CntW'(DEPTH);
        end
    end

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            head_tags_o[k] = mem_q[head_q + PtrW'(k)];
        end
    end

    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PRW'(ARCH_REGS + i);
            end
            head_q        <= '0;
            commit_head_q <= '0;
            tail_q        <= '0;
            count_q       <= CntW'(DEPTH);
        end else begin
            assert (count_q <= CntW'(DEPTH));
            for (int k = 0; k < WIDTH; k++) begin
                if (push_valid_i[k]) begin
                    mem_q[push_addr[k]] <= push_tag_i[k];
                end
            end
            head_q        <= head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: speculative RAT with intra-bundle bypass, retirement
// RAT updated at commit, free list of physical tags, registered output to dispatch.
module rename_stage import rename_stage_pkg::*; #(
    parameter int unsigned WIDTH = FRONTEND_WIDTH,
    parameter int unsigned NPR   = PHYS_REGS_SIZE,
    parameter int unsigned PRW   = PHYS_REGS_ADDR_SIZE
) (
    input  logic          clk,
    input  logic          reset,
    rename_stage_if.slave bus
);

    localparam int unsigned CntW = $clog2(NPR - ARCH_REGS + 1);
    localparam int unsigned PopW = $clog2(WIDTH + 1);

    logic [PRW-1:0]             rat_q [ARCH_REGS];
    logic [PRW-1:0]             rat_d [ARCH_REGS];
    logic [PRW-1:0]             rrat_q [ARCH_REGS];
    logic [PRW-1:0]             rrat_d [ARCH_REGS];
    instr_dec_t [WIDTH-1:0]     dec;
    logic [WIDTH-1:0]           alloc, push_valid, ren_valid_q;
    logic [PopW-1:0]            need, pop_cnt;
    logic [WIDTH-1:0][PRW-1:0]  free_tags, slot_prd;
    logic [CntW-1:0]            fl_count;
    logic                       out_free, dec_ready, accept;
    ren_instr_t [WIDTH-1:0]     ren_d, ren_instr_q;

    assign dec = bus.dec_instr_i;

    always_comb begin
        need = '0;
        for (int k = 0; k < WIDTH; k++) begin
            alloc[k] = bus.dec_valid_i[k] & dec[k].rd_v & (dec[k].rd != 5'd0);
            need     = need + PopW'(alloc[k]);
        end
    end

    assign out_free  = ~(|ren_valid_q) | bus.ren_ready_i;
    assign dec_ready = out_free & (fl_count >= CntW'(need)) & ~bus.flush_i & ~reset;
    assign accept    = dec_ready & (|bus.dec_valid_i);
    assign pop_cnt   = accept ? need : '0;

    // Each allocating slot takes the free tag past those claimed by older slots.
    always_comb begin
        slot_prd = '0;
        for (int k = 0; k < WIDTH; k++) begin
            int older;
            older = 0;
            for (int i = 0; i < k; i++) older = older + (alloc[i] ? 1 : 0);
            for (int j = 0; j < WIDTH; j++) begin
                if (alloc[k] && j == older) slot_prd[k] = free_tags[j];
            end
        end
    end

    // Later older-slot matches overwrite earlier ones, so the youngest older writer wins.
    always_comb begin
        rat_d = rat_q;
        ren_d = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.dec_valid_i[k]) begin
                ren_d[k].dec  = dec[k];
                ren_d[k].prs1 = rat_q[dec[k].rs1];
                ren_d[k].prs2 = rat_q[dec[k].rs2];
                if (alloc[k]) begin
                    ren_d[k].prd     = slot_prd[k];
                    ren_d[k].old_prd = rat_q[dec[k].rd];
                end
                for (int i = 0; i < k; i++) begin
                    if (alloc[i]) begin
                        if (dec[i].rd == dec[k].rs1) ren_d[k].prs1 = slot_prd[i];
                        if (dec[i].rd == dec[k].rs2) ren_d[k].prs2 = slot_prd[i];
                        if (alloc[k] && dec[i].rd == dec[k].rd) ren_d[k].old_prd = slot_prd[i];
                    end
                end
                if (alloc[k]) rat_d[dec[k].rd] = slot_prd[k];
            end
        end
    end

    always_comb begin
        rrat_d     = rrat_q;
        push_valid = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.commit_valid_i[k] && bus.commit_rd_i[k] != 5'd0) begin
                rrat_d[bus.commit_rd_i[k]] = bus.commit_prd_i[k];
                push_valid[k]              = 1'b1;
            end
        end
    end

    rename_free_list #(
        .WIDTH (WIDTH),
        .DEPTH (NPR - ARCH_REGS),
        .PRW   (PRW)
    ) u_free_list (
        .clk          (clk),
        .reset        (reset),
        .pop_cnt_i    (pop_cnt),
        .push_valid_i (push_valid),
        .push_tag_i   (bus.commit_old_prd_i),
        .flush_i      (bus.flush_i),
        .count_o      (fl_count),
        .head_tags_o  (free_tags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i]  <= PRW'(i);
                rrat_q[i] <= PRW'(i);
            end
            ren_valid_q <= '0;
            ren_instr_q <= '0;
        end else begin
            rrat_q <= rrat_d;
            if (bus.flush_i) begin
                rat_q       <= rrat_d;
                ren_valid_q <= '0;
                ren_instr_q <= '0;
            end else if (accept) begin
                rat_q       <= rat_d;
                ren_valid_q <= bus.dec_valid_i;
                ren_instr_q <= ren_d;
            end else if (bus.ren_ready_i) begin
                ren_valid_q <= '0;
                ren_instr_q <= '0;
            end
        end
    end

    assign bus.dec_ready_o = dec_ready;
    assign bus.ren_valid_o = ren_valid_q;
    assign bus.ren_instr_o = ren_instr_q;

endmodule

// File: tb/tb_rename_stage.sv
// Bench for rename_stage: queue-based reference model checked every cycle,
// plus directed bundles with hand-computed tags.
module tb_rename_stage;
    import rename_stage_pkg::*;

    localparam int W = FRONTEND_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    rename_stage_if bus ();

    rename_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pc_seq = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: free tags and in-flight allocations as ordered queues.
    int         m_rat [32];
    int         m_rrat [32];
    int         m_free [$];
    int         m_inflight [$];
    logic [W-1:0] m_valid = '0;
    ren_instr_t m_out [W];
    bit         m_live = 0;
    bit         m_fire;
    ren_instr_t m_rec;
    int         m_tag;

    function automatic bit exp_ready();
        int need = 0;
        for (int k = 0; k < W; k++) begin
            if (bus.dec_valid_i[k] && bus.dec_instr_i[k].rd_v && bus.dec_instr_i[k].rd != 0)
                need++;
        end
        return (m_valid == '0 || bus.ren_ready_i) && m_free.size() >= need &&
               !bus.flush_i && !reset;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_rat[i]  = i;
                m_rrat[i] = i;
            end
            m_free.delete();
            for (int t = 32; t < 64; t++) m_free.push_back(t);
            m_inflight.delete();
            m_valid = '0;
            m_live  = 1;
        end else begin
            m_fire = exp_ready() && (bus.dec_valid_i != '0);
            for (int k = 0; k < W; k++) begin
                if (bus.commit_valid_i[k] && bus.commit_rd_i[k] != 0) begin
                    m_rrat[bus.commit_rd_i[k]] = int'(bus.commit_prd_i[k]);
                    void'(m_inflight.pop_front());
                    m_free.push_back(int'(bus.commit_old_prd_i[k]));
                end
            end
            if (bus.flush_i) begin
                m_rat = m_rrat;
                m_free = {m_inflight, m_free};
                m_inflight.delete();
                m_valid = '0;
            end else if (m_fire) begin
                for (int k = 0; k < W; k++) begin
                    m_rec = '0;
                    if (bus.dec_valid_i[k]) begin
                        m_rec.dec  = bus.dec_instr_i[k];
                        m_rec.prs1 = ptag_t'(m_rat[m_rec.dec.rs1]);
                        m_rec.prs2 = ptag_t'(m_rat[m_rec.dec.rs2]);
                        if (m_rec.dec.rd_v && m_rec.dec.rd != 0) begin
                            m_tag = m_free.pop_front();
                            m_inflight.push_back(m_tag);
                            m_rec.prd     = ptag_t'(m_tag);
                            m_rec.old_prd = ptag_t'(m_rat[m_rec.dec.rd]);
                            m_rat[m_rec.dec.rd] = m_tag;
                        end
                    end
                    m_out[k] = m_rec;
                end
                m_valid = bus.dec_valid_i;
            end else if (bus.ren_ready_i) begin
                m_valid = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("dec_ready", bus.dec_ready_o, exp_ready());
            check("ren_valid", bus.ren_valid_o, m_valid);
            for (int k = 0; k < W; k++) begin
                if (m_valid[k]) check($sformatf("ren_instr[%0d]", k), bus.ren_instr_o[k], m_out[k]);
            end
        end
    end

    task automatic slot(input int k, input int rd, input int rs1, input int rs2, input bit rd_v);
        instr_dec_t d;
        d.pc     = 32'h1000 + 32'(pc_seq * 4);
        d.opcode = rd_v ? 7'h33 : 7'h23;
        d.rd     = 5'(rd);
        d.rs1    = 5'(rs1);
        d.rs2    = 5'(rs2);
        d.rd_v   = rd_v;
        d.rs1_v  = 1'b1;
        d.rs2_v  = (rs2 != 0);
        pc_seq++;
        bus.dec_instr_i[k] = d;
        bus.dec_valid_i[k] = 1'b1;
    endtask

    task automatic idle();
        bus.dec_valid_i      = '0;
        bus.dec_instr_i      = '0;
        bus.commit_valid_i   = '0;
        bus.commit_rd_i      = '0;
        bus.commit_prd_i     = '0;
        bus.commit_old_prd_i = '0;
        bus.flush_i          = 1'b0;
    endtask

    task automatic commit(input int k, input int rd, input int prd, input int old);
        bus.commit_valid_i[k]   = 1'b1;
        bus.commit_rd_i[k]      = 5'(rd);
        bus.commit_prd_i[k]     = ptag_t'(prd);
        bus.commit_old_prd_i[k] = ptag_t'(old);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic chk_slot(input string name, input int k, input int prs1, input int prs2,
                            input int prd, input int old);
        check({name, " prs1"}, bus.ren_instr_o[k].prs1, prs1);
        check({name, " prs2"}, bus.ren_instr_o[k].prs2, prs2);
        check({name, " prd"}, bus.ren_instr_o[k].prd, prd);
        check({name, " old_prd"}, bus.ren_instr_o[k].old_prd, old);
    endtask

    initial begin
        idle();
        bus.ren_ready_i = 1'b1;
        do_reset();
        check("reset count", dut.u_free_list.count_q, 32);
        check("reset ren_valid", bus.ren_valid_o, 0);

        // add x5,x1,x2 ; add x6,x5,x5
        slot(0, 5, 1, 2, 1);
        slot(1, 6, 5, 5, 1);
        step();
        idle();
        chk_slot("t1 s0", 0, 1, 2, 32, 5);
        chk_slot("t1 s1", 1, 32, 32, 33, 6);
        check("t1 count", dut.u_free_list.count_q, 30);

        // addi x7 ; addi x7, then read x7
        do_reset();
        slot(0, 7, 1, 0, 1);
        slot(1, 7, 7, 0, 1);
        step();
        idle();
        chk_slot("t2 s0", 0, 1, 0, 32, 7);
        chk_slot("t2 s1", 1, 32, 0, 33, 32);
        slot(0, 9, 7, 0, 1);
        step();
        idle();
        chk_slot("t2 rat7", 0, 33, 0, 34, 9);

        // sw ; add x0 -> no allocation, then drain the free list
        do_reset();
        slot(0, 0, 1, 2, 0);
        slot(1, 0, 1, 1, 1);
        step();
        idle();
        chk_slot("t3 sw", 0, 1, 2, 0, 0);
        chk_slot("t3 x0", 1, 1, 1, 0, 0);
        check("t3 count", dut.u_free_list.count_q, 32);
        for (int b = 0; b < 16; b++) begin
            slot(0, 5, 1, 2, 1);
            slot(1, 6, 5, 5, 1);
            step();
        end
        idle();
        check("t3 drained", dut.u_free_list.count_q, 0);
        slot(0, 9, 1, 2, 1);
        #1;
        check("t3 starved", bus.dec_ready_o, 0);
        step();
        commit(0, 5, 32, 5);
        #1;
        check("t3 no commit bypass", bus.dec_ready_o, 0);
        step();
        bus.commit_valid_i = '0;
        #1;
        check("t3 count after commit", dut.u_free_list.count_q, 1);
        check("t3 ready after commit", bus.dec_ready_o, 1);
        step();
        idle();
        chk_slot("t3 reuse", 0, 1, 2, 5, 9);

        // dispatch back-pressure for 3 cycles
        do_reset();
        bus.ren_ready_i = 1'b0;
        slot(0, 5, 1, 2, 1);
        slot(1, 6, 5, 5, 1);
        step();
        idle();
        slot(0, 8, 5, 6, 1);
        slot(1, 9, 8, 0, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t4 hold ready", bus.dec_ready_o, 0);
            check("t4 hold valid", bus.ren_valid_o, 3);
            check("t4 hold s0 prd", bus.ren_instr_o[0].prd, 32);
            check("t4 hold s1 prd", bus.ren_instr_o[1].prd, 33);
            step();
        end
        bus.ren_ready_i = 1'b1;
        #1;
        check("t4 release ready", bus.dec_ready_o, 1);
        step();
        idle();
        chk_slot("t4 s0", 0, 32, 33, 34, 8);
        chk_slot("t4 s1", 1, 34, 0, 35, 9);

        // commit the first of two renames together with a flush
        do_reset();
        slot(0, 5, 1, 2, 1);
        slot(1, 6, 5, 5, 1);
        step();
        idle();
        commit(0, 5, 32, 5);
        bus.flush_i = 1'b1;
        #1;
        check("t5 flush ready", bus.dec_ready_o, 0);
        step();
        idle();
        check("t5 flush valid", bus.ren_valid_o, 0);
        check("t5 flush count", dut.u_free_list.count_q, 32);
        check("t5 flush head", dut.u_free_list.head_q, 1);
        slot(0, 8, 5, 6, 1);
        step();
        idle();
        chk_slot("t5 after flush", 0, 32, 6, 33, 8);

        // flush and reset together mid-stream
        slot(0, 10, 1, 2, 1);
        slot(1, 11, 10, 3, 1);
        step();
        slot(0, 12, 10, 11, 1);
        commit(0, 8, 33, 8);
        bus.flush_i = 1'b1;
        reset = 1'b1;
        #1;
        check("t6 reset ready", bus.dec_ready_o, 0);
        step();
        reset = 1'b0;
        idle();
        check("t6 reset valid", bus.ren_valid_o, 0);
        check("t6 reset count", dut.u_free_list.count_q, 32);
        slot(0, 5, 5, 6, 1);
        step();
        idle();
        chk_slot("t6 after reset", 0, 5, 6, 32, 5);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
